// File: rtl/accel_stream_pkg.sv
// Shared types for the accelerator stream blocks: reader FSM encoding
// and skid-buffer sizing derived from BRAM read latency.
package accel_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int CNT_W = 3;

  function automatic int skid_depth(input int rd_lat);
    return rd_lat + 1;
  endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready word stream from the BRAM reader toward the core.
// ms_last exists only when BRAM_READER_LAST_EN is defined.
interface bram_stream_reader_if #(
  parameter int WIDTH = 72
);
  logic [WIDTH-1:0] ms_data;
  logic             ms_valid;
  logic             ms_ready;
`ifdef BRAM_READER_LAST_EN
  logic             ms_last;

  modport master (
    output ms_data, ms_valid, ms_last,
    input  ms_ready
  );
  modport slave (
    input  ms_data, ms_valid, ms_last,
    output ms_ready
  );
`else
  modport master (
    output ms_data, ms_valid,
    input  ms_ready
  );
  modport slave (
    input  ms_data, ms_valid,
    output ms_ready
  );
`endif
endinterface

// File: rtl/stream_skid_fifo.sv
// Small register FIFO that absorbs BRAM returns; head is a register,
// so the read side has no combinational path from rd_en.
module stream_skid_fifo
  import accel_stream_pkg::*;
#(
  parameter int W     = 72,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp      <= nxt(wp);
      end
      if (rd_en) rp <= nxt(rp);
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  assign rd_data = mem[rp];

endmodule

// File: rtl/bram_stream_reader.sv
// Command-driven sequential BRAM reader with credit-gated skid buffer.
// Optional ms_last beat marker: define BRAM_READER_LAST_EN.
module bram_stream_reader
  import accel_stream_pkg::*;
#(
  parameter int WIDTH     = 72,
  parameter int DEPTH     = 512,
  parameter int LOG_DEPTH = 9,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [LOG_DEPTH-1:0] cmd_addr,
  input  logic [LOG_DEPTH:0]   cmd_len,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic [LOG_DEPTH-1:0] bram_addr,
  output logic                 bram_en,
  input  logic [WIDTH-1:0]     bram_rdata,
  output logic                 busy,
  output logic                 done,
  bram_stream_reader_if.master ms
);

  localparam int SD = skid_depth(RD_LAT);
`ifdef BRAM_READER_LAST_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif
  localparam logic [LOG_DEPTH-1:0] A_LAST = LOG_DEPTH'(DEPTH - 1);
  localparam logic [LOG_DEPTH:0]   R_ONE  = (LOG_DEPTH+1)'(1);

  state_t               state;
  logic [LOG_DEPTH-1:0] addr;
  logic [LOG_DEPTH:0]   remaining;
  logic [RD_LAT-1:0]    rd_vld;
  logic [CNT_W-1:0]     occ;
  logic [CNT_W-1:0]     infl;
  logic [CNT_W-1:0]     used;
  logic                 accept;
  logic                 issue;
  logic                 pop;
  logic [FW-1:0]        wr_data;
  logic [FW-1:0]        rd_data;

  assign accept = cmd_valid && cmd_ready;
  assign pop    = ms.ms_valid && ms.ms_ready;

  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++)
      infl = infl + CNT_W'(rd_vld[i]);
  end

  // Credits: every issued read must find a free skid slot on return.
  assign used      = infl + occ - CNT_W'(pop);
  assign issue     = (state == RUN) && (remaining != '0)
                     && (used < CNT_W'(SD));
  assign bram_en   = issue;
  assign bram_addr = addr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_vld <= '0;
    end else begin
      rd_vld[0] <= issue;
      for (int i = 1; i < RD_LAT; i++)
        rd_vld[i] <= rd_vld[i-1];
    end
  end

`ifdef BRAM_READER_LAST_EN
  logic [RD_LAT-1:0] rd_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_last <= '0;
    end else begin
      rd_last[0] <= issue && (remaining == R_ONE);
      for (int i = 1; i < RD_LAT; i++)
        rd_last[i] <= rd_last[i-1];
    end
  end

  assign wr_data = {rd_last[RD_LAT-1], bram_rdata};
  assign {ms.ms_last, ms.ms_data} = rd_data;
`else
  assign wr_data    = bram_rdata;
  assign ms.ms_data = rd_data;
`endif

  stream_skid_fifo #(
    .W     (FW),
    .DEPTH (SD)
  ) u_skid (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (rd_vld[RD_LAT-1]),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .count   (occ)
  );

  assign ms.ms_valid = (occ != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr      <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_len != '0) begin
              addr      <= cmd_addr;
              remaining <= cmd_len;
              state     <= RUN;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr      <= (addr == A_LAST) ? '0 : addr + LOG_DEPTH'(1);
            remaining <= remaining - R_ONE;
            if (remaining == R_ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish in the cycle the final beat leaves the buffer.
          if (infl == '0 && occ == CNT_W'(pop)) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Runs RD_LAT=1 and RD_LAT=2 readers side by side against a
// queue-free reference: beat k of (a,len) must be word (a+k) mod DEPTH.
module tb_bram_stream_reader;

  localparam int W  = 72;
  localparam int D  = 512;
  localparam int LD = 9;
  localparam int NB = 600;

  logic          clk;
  logic          resetn;
  logic          cval;
  logic [LD-1:0] caddr;
  logic [LD:0]   clen;
  logic          cr1, cr2;
  logic [LD-1:0] ba1, ba2;
  logic          be1, be2;
  logic [W-1:0]  rd1, rd2, p2;
  logic          bz1, bz2;
  logic          dn1, dn2;
  logic          rdy;
  logic          l1, l2;

  int tests = 0;
  int fails = 0;
  int rmode = 0;
  int ph    = 0;

  bram_stream_reader_if #(.WIDTH(W)) s1 ();
  bram_stream_reader_if #(.WIDTH(W)) s2 ();

  assign s1.ms_ready = rdy;
  assign s2.ms_ready = rdy;
`ifdef BRAM_READER_LAST_EN
  assign l1 = s1.ms_last;
  assign l2 = s2.ms_last;
`else
  assign l1 = 1'b0;
  assign l2 = 1'b0;
`endif

  bram_stream_reader #(
    .WIDTH(W), .DEPTH(D), .LOG_DEPTH(LD), .RD_LAT(1)
  ) u1 (
    .clk(clk), .resetn(resetn),
    .cmd_addr(caddr), .cmd_len(clen),
    .cmd_valid(cval), .cmd_ready(cr1),
    .bram_addr(ba1), .bram_en(be1), .bram_rdata(rd1),
    .busy(bz1), .done(dn1), .ms(s1)
  );

  bram_stream_reader #(
    .WIDTH(W), .DEPTH(D), .LOG_DEPTH(LD), .RD_LAT(2)
  ) u2 (
    .clk(clk), .resetn(resetn),
    .cmd_addr(caddr), .cmd_len(clen),
    .cmd_valid(cval), .cmd_ready(cr2),
    .bram_addr(ba2), .bram_en(be2), .bram_rdata(rd2),
    .busy(bz2), .done(dn2), .ms(s2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM contents: word[i] = i
  always @(posedge clk) begin
    if (be1) rd1 <= W'(ba1);
    if (be2) p2 <= W'(ba2);
    rd2 <= p2;
  end

  task automatic chk(input string tag, input logic [79:0] got,
                     input logic [79:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] gd [2][NB];
  logic         gl [2][NB];
  int           n      [2];
  int           dcnt   [2];
  int           bsy    [2];
  int           seen   [2];
  int           tfirst [2];
  int           tlast  [2];
  int           tdone  [2];
  logic         stl    [2];
  logic [W-1:0] pdat   [2];
  logic         plst   [2];

  task automatic mon(input int d, input logic v, input logic [W-1:0] dat,
                     input logic lst, input logic dn, input logic bz);
    if (!resetn) begin
      stl[d] = 1'b0;
    end else begin
      if (stl[d]) begin
        chk($sformatf("hold_valid%0d", d + 1), 80'(v), 80'(1));
        chk($sformatf("hold_data%0d", d + 1), 80'(dat), 80'(pdat[d]));
        chk($sformatf("hold_last%0d", d + 1), 80'(lst), 80'(plst[d]));
      end
      if (dn) begin
        dcnt[d]++;
        tdone[d] = int'($time);
      end
      if (bz) bsy[d] = 1;
      if (v && seen[d] == 0) begin
        seen[d]   = 1;
        tfirst[d] = int'($time);
      end
      if (v && rdy) begin
        if (n[d] < NB) begin
          gd[d][n[d]] = dat;
          gl[d][n[d]] = lst;
        end
        n[d]++;
        tlast[d] = int'($time);
      end
      stl[d]  = v && !rdy;
      pdat[d] = dat;
      plst[d] = lst;
    end
  endtask

  always @(negedge clk) begin
    mon(0, s1.ms_valid, s1.ms_data, l1, dn1, bz1);
    mon(1, s2.ms_valid, s2.ms_data, l2, dn2, bz2);
  end

  // ms_ready pattern: 0 = always, 1 = 1,0,0 repeating, 2 = random
  initial begin
    rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1:       rdy = (ph % 3 == 0);
        2:       rdy = ($urandom_range(0, 9) < 7);
        default: rdy = 1'b1;
      endcase
      ph++;
    end
  end

  task automatic clear_rec();
    for (int d = 0; d < 2; d++) begin
      n[d]    = 0;
      dcnt[d] = 0;
      bsy[d]  = 0;
      seen[d] = 0;
    end
  endtask

  task automatic send(input int a, input int len);
    @(posedge clk);
    #1;
    chk("cmd_ready1", 80'(cr1), 80'(1));
    chk("cmd_ready2", 80'(cr2), 80'(1));
    caddr = LD'(a);
    clen  = (LD+1)'(len);
    cval  = 1'b1;
  endtask

  task automatic run_cmd(input int a, input int len, input int mode);
    int t0;
    int w;
    rmode = mode;
    ph    = 0;
    clear_rec();
    send(a, len);
    @(posedge clk);
    t0 = int'($time);
    #1 cval = 1'b0;
    w = 0;
    while (!(dcnt[0] > 0 && dcnt[1] > 0) && w < 3000) begin
      @(posedge clk);
      w++;
    end
    chk("done_timeout", 80'(w < 3000), 80'(1));
    repeat (6) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("nbeats%0d", d + 1), 80'(n[d]), 80'(len));
      chk($sformatf("done_cnt%0d", d + 1), 80'(dcnt[d]), 80'(1));
      for (int k = 0; k < len && k < n[d] && k < NB; k++) begin
        chk($sformatf("beat%0d_%0d", d + 1, k), 80'(gd[d][k]),
            80'((a + k) % D));
`ifdef BRAM_READER_LAST_EN
        chk($sformatf("last%0d_%0d", d + 1, k), 80'(gl[d][k]),
            80'(k == len - 1));
`endif
      end
      if (len == 0) begin
        chk($sformatf("busy0_%0d", d + 1), 80'(bsy[d]), 80'(0));
        chk($sformatf("done0_lat%0d", d + 1), 80'(tdone[d] - t0), 80'(5));
      end else begin
        chk($sformatf("busy%0d", d + 1), 80'(bsy[d]), 80'(1));
        chk($sformatf("first_lat%0d", d + 1), 80'(tfirst[d] - t0),
            80'(10 * (d + 2) + 5));
        chk($sformatf("done_lat%0d", d + 1), 80'(tdone[d] - tlast[d]),
            80'(10));
        if (mode == 0)
          chk($sformatf("b2b%0d", d + 1), 80'(tlast[d] - tfirst[d]),
              80'(10 * (len - 1)));
      end
    end
  endtask

  initial begin
    int w;
    resetn = 1'b0;
    cval   = 1'b0;
    caddr  = '0;
    clen   = '0;
    clear_rec();
    #12;
    chk("rst_cmd_ready", 80'({cr1, cr2}), 80'(2'b11));
    chk("rst_valid", 80'({s1.ms_valid, s2.ms_valid}), 80'(0));
    chk("rst_en", 80'({be1, be2}), 80'(0));
    chk("rst_addr", 80'({ba1, ba2}), 80'(0));
    chk("rst_data1", 80'(s1.ms_data), 80'(0));
    chk("rst_busy_done", 80'({bz1, bz2, dn1, dn2}), 80'(0));
    @(posedge clk);
    #1 resetn = 1'b1;

    run_cmd(10, 4, 0);
    run_cmd(510, 5, 0);
    run_cmd(0, 8, 1);
    run_cmd(7, 0, 0);

    // reset mid-RUN
    rmode = 0;
    clear_rec();
    send(100, 16);
    @(posedge clk);
    #1 cval = 1'b0;
    w = 0;
    while (n[0] < 3 && w < 200) begin
      @(posedge clk);
      w++;
    end
    chk("mid_timeout", 80'(w < 200), 80'(1));
    #2 resetn = 1'b0;
    #1;
    chk("mid_valid", 80'({s1.ms_valid, s2.ms_valid}), 80'(0));
    chk("mid_ready", 80'({cr1, cr2}), 80'(2'b11));
    chk("mid_busy_en", 80'({bz1, bz2, be1, be2}), 80'(0));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    run_cmd(0, 2, 0);

    run_cmd(300, D, 0);

    for (int i = 0; i < 10; i++)
      run_cmd($urandom_range(0, D - 1), $urandom_range(0, 24),
              $urandom_range(0, 2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
